// File: rtl/dram_cache_pkg.sv
// Shared types and widths for the DRAM cache memory port.
// Tag word layout and the read response bundle live here.
package dram_cache_pkg;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 512;
  localparam int ID_W     = 16;
  localparam int TAG_S    = 64;
  localparam int TAG_W    = 32;
  localparam int INDEX_W  = 26;
  localparam int OFFSET_W = 6;
  localparam int BLANK_W  = 30;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_W-1:0]   tag;
    logic [BLANK_W-1:0] blank;
  } tag_word_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    tag_word_t         tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/dram_cache_mem_slave_if.sv
// Memory-port bundle between the DRAM cache controller and memory.
// Signal suffixes are from the memory (slave) side.
interface dram_cache_mem_slave_if;
  import dram_cache_pkg::*;

  logic [ID_W-1:0]         arid_i;
  logic [ADDR_W-1:0]       araddr_i;
  logic                    arvalid_i;
  logic                    arready_o;

  logic [ID_W-1:0]         rid_o;
  logic [TAG_S+DATA_W-1:0] rdata_o;
  logic                    rvalid_o;
  logic                    rready_i;

  logic [ID_W-1:0]         awid_i;
  logic [ADDR_W-1:0]       awaddr_i;
  logic                    awvalid_i;
  logic                    awready_o;

  logic [ID_W-1:0]         wid_i;
  logic [DATA_W-1:0]       wdata_i;
  logic                    wvalid_i;
  logic                    wready_o;

  logic [ID_W-1:0]         bid_o;
  logic                    bvalid_o;
  logic                    bready_i;

  modport slave (
    input  arid_i, araddr_i, arvalid_i,
    output arready_o,
    output rid_o, rdata_o, rvalid_o,
    input  rready_i,
    input  awid_i, awaddr_i, awvalid_i,
    output awready_o,
    input  wid_i, wdata_i, wvalid_i,
    output wready_o,
    output bid_o, bvalid_o,
    input  bready_i
  );

  modport master (
    output arid_i, araddr_i, arvalid_i,
    input  arready_o,
    input  rid_o, rdata_o, rvalid_o,
    output rready_i,
    output awid_i, awaddr_i, awvalid_i,
    input  awready_o,
    output wid_i, wdata_i, wvalid_i,
    input  wready_o,
    input  bid_o, bvalid_o,
    output bready_i
  );

endinterface

// File: rtl/dram_cache_rsp_fifo.sv
// Synchronous FIFO with full/empty flags.
// Queues read responses in front of the R channel.
module dram_cache_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push, pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign dout_o  = mem_q[rp_q];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push)
      wp_d = (wp_q == PW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
    if (pop)
      rp_d = (rp_q == PW'(DEPTH-1)) ? '0 : rp_q + 1'b1;
    if (push & ~pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop & ~push)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/dram_cache_mem_slave.sv
// DRAM device model: tag + data arrays behind the cache memory port.
// MEM_BACKDOOR_EN adds zero-time preload/peek tasks for benches.
module dram_cache_mem_slave
  import dram_cache_pkg::*;
#(
  parameter int IDX_BITS  = 10,
  parameter int RD_LAT    = 4,
  parameter int RSP_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  dram_cache_mem_slave_if.slave s
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  tag_word_t         tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic                aw_full_q, w_full_q, bvalid_q;
  logic                awsel_q;
  logic [IDX_BITS-1:0] awidx_q;
  logic [ID_W-1:0]     awid_q, bid_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                aw_hs, w_hs, b_hs, commit;
  tag_word_t           new_tag;

  assign s.awready_o = ~aw_full_q;
  assign s.wready_o  = ~w_full_q;
  assign s.bvalid_o  = bvalid_q;
  assign s.bid_o     = bid_q;

  assign aw_hs   = s.awvalid_i & ~aw_full_q;
  assign w_hs    = s.wvalid_i & ~w_full_q;
  assign b_hs    = bvalid_q & s.bready_i;
  assign commit  = aw_full_q & w_full_q & ~bvalid_q;
  assign new_tag = tag_word_t'(wdata_q[TAG_S-1:0]);

  // Holding registers stay full until B is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awsel_q   <= 1'b0;
      awidx_q   <= '0;
      awid_q    <= '0;
      bid_q     <= '0;
    end else begin
      if (b_hs) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_full_q <= 1'b1;
        if (w_hs)  w_full_q  <= 1'b1;
      end
      if (aw_hs) begin
        awid_q  <= s.awid_i;
        awsel_q <= s.awaddr_i[ADDR_W-1];
        awidx_q <= s.awaddr_i[OFFSET_W +: IDX_BITS];
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bid_q    <= awid_q;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs)
      wdata_q <= s.wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        tag_mem[i] <= '0;
    end else if (commit & awsel_q) begin
      tag_mem[awidx_q] <= new_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (commit & ~awsel_q)
      data_mem[awidx_q] <= wdata_q;
  end

  logic                ar_hs, r_hs, f_empty, f_full;
  logic [IDX_BITS-1:0] ridx;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  rsp_t                rd_d, head;
  logic [RSP_W-1:0]    f_dout;
  logic [RD_LAT-1:0]   pv_q;
  rsp_t                pl_q [RD_LAT];

  assign ridx        = s.araddr_i[OFFSET_W +: IDX_BITS];
  assign s.arready_o = (cnt_q < CNT_W'(RSP_DEPTH));
  assign ar_hs       = s.arvalid_i & s.arready_o;
  assign r_hs        = ~f_empty & s.rready_i;

  // Write-first: a same-edge commit to this index wins.
  always_comb begin
    rd_d.id   = s.arid_i;
    rd_d.tag  = tag_mem[ridx];
    rd_d.data = data_mem[ridx];
    if (commit && (awidx_q == ridx)) begin
      if (awsel_q) rd_d.tag  = new_tag;
      else         rd_d.data = wdata_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs & ~r_hs)
      cnt_d = cnt_q + 1'b1;
    else if (r_hs & ~ar_hs)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pv_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pv_q[0] <= ar_hs;
      for (int i = 1; i < RD_LAT; i++)
        pv_q[i] <= pv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pl_q[0] <= rd_d;
    for (int i = 1; i < RD_LAT; i++)
      pl_q[i] <= pl_q[i-1];
  end

  dram_cache_rsp_fifo #(
    .W     (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pv_q[RD_LAT-1]),
    .din_i   (pl_q[RD_LAT-1]),
    .pop_i   (r_hs),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign head      = f_dout;
  assign s.rvalid_o = ~f_empty;
  assign s.rid_o    = f_empty ? '0 : head.id;
  assign s.rdata_o  = f_empty ? '0 : {head.tag, head.data};

  logic unused_bits;
  assign unused_bits = ^{s.araddr_i[ADDR_W-1:OFFSET_W+IDX_BITS],
                         s.araddr_i[OFFSET_W-1:0],
                         s.awaddr_i[ADDR_W-2:OFFSET_W+IDX_BITS],
                         s.awaddr_i[OFFSET_W-1:0],
                         s.wid_i, f_full};

`ifdef MEM_BACKDOOR_EN
  task automatic write_8byte(input int unsigned index,
                             input logic [TAG_S-1:0] tw);
    tag_mem[index[IDX_BITS-1:0]] = tag_word_t'(tw);
  endtask

  task automatic write_64byte(input int unsigned index,
                              input logic [DATA_W-1:0] d);
    data_mem[index[IDX_BITS-1:0]] = d;
  endtask

  function automatic logic [TAG_S-1:0] read_8byte(input int unsigned index);
    return tag_mem[index[IDX_BITS-1:0]];
  endfunction

  function automatic logic [DATA_W-1:0] read_64byte(input int unsigned index);
    return data_mem[index[IDX_BITS-1:0]];
  endfunction
`endif

endmodule

// File: tb/tb_dram_cache_mem_slave.sv
// Directed bench for dram_cache_mem_slave.
// Hand-computed expectations, immediate assertions per check.
module tb_dram_cache_mem_slave;

  localparam int RD_LAT = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dram_cache_mem_slave_if bus();

  dram_cache_mem_slave #(
    .IDX_BITS  (10),
    .RD_LAT    (RD_LAT),
    .RSP_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0]  TAGW = 64'hc0000003c0000000;
  localparam logic [511:0] DDD  = {128{4'hd}};
  localparam logic [511:0] D1   = {128{4'h1}};
  localparam logic [511:0] D2   = {128{4'h2}};
  localparam logic [511:0] D3   = {128{4'h3}};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t, input logic [575:0] o,
                     input logic [575:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic issue_ar(input logic [15:0] id, input logic [63:0] a);
    bus.arid_i    = id;
    bus.araddr_i  = a;
    bus.arvalid_i = 1'b1;
    tick;
    bus.arvalid_i = 1'b0;
  endtask

  task automatic wait_r(input logic [15:0] id, output logic [575:0] got);
    int lat;
    lat = 0;
    while (!bus.rvalid_o && lat < 20) begin
      tick;
      lat++;
    end
    chk("r_latency", lat, RD_LAT);
    chk("r_id", bus.rid_o, id);
    got = bus.rdata_o;
    tick;
    chk("r_drained", bus.rvalid_o, 1'b0);
  endtask

  task automatic rd(input logic [15:0] id, input logic [63:0] a,
                    output logic [575:0] got);
    issue_ar(id, a);
    wait_r(id, got);
  endtask

  task automatic bresp;
    bus.bready_i = 1'b1;
    tick;
    bus.bready_i = 1'b0;
    chk("b_clear", bus.bvalid_o, 1'b0);
    chk("aw_reopen", bus.awready_o, 1'b1);
    chk("w_reopen", bus.wready_o, 1'b1);
  endtask

  task automatic wr(input logic [15:0] id, input logic [63:0] a,
                    input logic [511:0] d);
    bus.awid_i    = id;
    bus.awaddr_i  = a;
    bus.wdata_i   = d;
    bus.awvalid_i = 1'b1;
    bus.wvalid_i  = 1'b1;
    tick;
    bus.awvalid_i = 1'b0;
    bus.wvalid_i  = 1'b0;
    chk("wr_b_early", bus.bvalid_o, 1'b0);
    tick;
    chk("wr_b_set", bus.bvalid_o, 1'b1);
    chk("wr_bid", bus.bid_o, id);
    bresp;
  endtask

  logic [575:0] got;
  logic [15:0]  got_id;
  logic         ar_go, r_go, seen;
  int           n, guard;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.arid_i = '0; bus.araddr_i = '0; bus.arvalid_i = 1'b0;
    bus.rready_i = 1'b1;
    bus.awid_i = '0; bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
    bus.wid_i = '0; bus.wdata_i = '0; bus.wvalid_i = 1'b0;
    bus.bready_i = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    chk("rst_arready", bus.arready_o, 1'b1);
    chk("rst_awready", bus.awready_o, 1'b1);
    chk("rst_wready", bus.wready_o, 1'b1);
    chk("rst_rvalid", bus.rvalid_o, 1'b0);
    chk("rst_bvalid", bus.bvalid_o, 1'b0);
    chk("rst_rid", bus.rid_o, 16'h0);
    chk("rst_rdata", bus.rdata_o, 576'h0);
    chk("rst_bid", bus.bid_o, 16'h0);

    rd(16'h7, 64'h40, got);
    chk("rst_tag_idx1", got[575:512], 64'h0);

    wr(16'h11, 64'h8000000000000040, {448'h0, TAGW});
    wr(16'h12, 64'h40, DDD);
    rd(16'h13, 64'h40, got);
    chk("tag_data_idx1", got, {TAGW, DDD});

    bus.wdata_i  = D1;
    bus.wvalid_i = 1'b1;
    tick;
    bus.wvalid_i = 1'b0;
    chk("wfirst_wready", bus.wready_o, 1'b0);
    repeat (3) tick;
    chk("wfirst_no_b", bus.bvalid_o, 1'b0);
    bus.awid_i    = 16'h21;
    bus.awaddr_i  = 64'h80;
    bus.awvalid_i = 1'b1;
    tick;
    bus.awvalid_i = 1'b0;
    chk("wfirst_b_early", bus.bvalid_o, 1'b0);
    tick;
    chk("wfirst_b_set", bus.bvalid_o, 1'b1);
    chk("wfirst_bid", bus.bid_o, 16'h21);
    tick;
    tick;
    chk("wfirst_aw_hold", bus.awready_o, 1'b0);
    chk("wfirst_w_hold", bus.wready_o, 1'b0);
    bresp;

    bus.awid_i    = 16'h22;
    bus.awaddr_i  = 64'h80;
    bus.awvalid_i = 1'b1;
    tick;
    bus.awvalid_i = 1'b0;
    chk("awfirst_awready", bus.awready_o, 1'b0);
    tick;
    bus.wdata_i  = D2;
    bus.wvalid_i = 1'b1;
    tick;
    bus.wvalid_i = 1'b0;
    chk("awfirst_b_early", bus.bvalid_o, 1'b0);
    tick;
    chk("awfirst_b_set", bus.bvalid_o, 1'b1);
    chk("awfirst_bid", bus.bid_o, 16'h22);
    chk("awfirst_w_hold", bus.wready_o, 1'b0);
    bresp;
    rd(16'h23, 64'h80, got);
    chk("idx2_data", got, {64'h0, D2});

    rd(16'h24, 64'h0000010000000040, got);
    chk("alias_idx1", got, {TAGW, DDD});

    bus.rready_i  = 1'b0;
    bus.araddr_i  = 64'h40;
    bus.arvalid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.arid_i = 16'(i);
      tick;
    end
    chk("bp_arready_low", bus.arready_o, 1'b0);
    bus.arid_i = 16'h5;
    repeat (6) tick;
    chk("bp_still_low", bus.arready_o, 1'b0);
    chk("bp_rvalid", bus.rvalid_o, 1'b1);
    chk("bp_head_id", bus.rid_o, 16'h1);
    chk("bp_head_data", bus.rdata_o, {TAGW, DDD});
    bus.rready_i = 1'b1;
    n = 0;
    guard = 0;
    while (n < 6 && guard < 60) begin
      ar_go  = bus.arvalid_i && bus.arready_o;
      r_go   = bus.rvalid_o && bus.rready_i;
      got_id = bus.rid_o;
      tick;
      guard++;
      if (r_go) begin
        chk("bp_order", got_id, 16'(n + 1));
        n++;
      end
      if (ar_go) begin
        if (bus.arid_i == 16'h5) bus.arid_i = 16'h6;
        else bus.arvalid_i = 1'b0;
      end
    end
    chk("bp_count", n, 6);
    chk("bp_ar_done", bus.arvalid_i, 1'b0);

    bus.awid_i    = 16'h31;
    bus.awaddr_i  = 64'h80;
    bus.wdata_i   = D3;
    bus.awvalid_i = 1'b1;
    bus.wvalid_i  = 1'b1;
    tick;
    bus.awvalid_i = 1'b0;
    bus.wvalid_i  = 1'b0;
    issue_ar(16'h9, 64'h80);
    chk("coll_b_set", bus.bvalid_o, 1'b1);
    wait_r(16'h9, got);
    chk("coll_bypass", got, {64'h0, D3});
    bresp;

    issue_ar(16'h55, 64'h40);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick;
      seen |= bus.rvalid_o;
    end
    chk("rst_drop_read", seen, 1'b0);
    rd(16'h56, 64'h40, got);
    chk("rst_keeps_data", got, {64'h0, DDD});

`ifdef MEM_BACKDOOR_EN
    dut.write_8byte(1, TAGW);
    rd(16'h57, 64'h40, got);
    chk("backdoor_tag", got, {TAGW, DDD});
    chk("backdoor_peek", dut.read_8byte(1), TAGW);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
